// File: rtl/scan_test_sequencer_if.sv
// Pattern delivery channel between a pattern source and the scan test sequencer.
interface scan_test_sequencer_if #(
  parameter int unsigned CHAIN_LEN = 2
);
  logic                 pat_valid;
  logic                 pat_ready;
  logic [CHAIN_LEN-1:0] pat_scan_in;
  logic                 pat_pi;
  logic                 exp_po;
  logic [CHAIN_LEN-1:0] exp_ppo;
  logic                 pat_last;

  modport master (
    output pat_valid, pat_scan_in, pat_pi, exp_po, exp_ppo, pat_last,
    input  pat_ready
  );

  modport slave (
    input  pat_valid, pat_scan_in, pat_pi, exp_po, exp_ppo, pat_last,
    output pat_ready
  );
endinterface

// File: rtl/scan_test_sequencer.sv
// Full-scan test sequencer: loads a pattern, shifts PPIs into a modelled scan chain,
// captures PO/PPO in one cycle and keeps pattern/failure counts for the session.
module scan_test_sequencer #(
  parameter int unsigned CHAIN_LEN = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 fault_inject,
  scan_test_sequencer_if.slave pat,
  output logic                 core_pi,
  output logic [CHAIN_LEN-1:0] core_ppi,
  output logic                 core_h0,
  input  logic                 core_po,
  input  logic [CHAIN_LEN-1:0] core_ppo,
  output logic                 shift_en,
  output logic                 scan_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     pattern_count,
  output logic [CNT_W-1:0]     fail_count
);

  localparam int unsigned      IDX_W    = (CHAIN_LEN > 2) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t               state;
  logic [CHAIN_LEN-1:0] sreg;
  logic [CHAIN_LEN-1:0] pat_q;
  logic [CHAIN_LEN-1:0] exp_ppo_q;
  logic                 exp_po_q;
  logic                 last_q;
  logic [IDX_W-1:0]     idx;
  logic                 mismatch_c;
  logic [CNT_W-1:0]     fail_next_c;

  // The scan register is the core's PPI source; its MSB is the serial scan-out.
  assign pat.pat_ready = (state == S_LOAD);
  assign core_ppi      = sreg;
  assign scan_out      = sreg[CHAIN_LEN-1];

  assign mismatch_c  = (core_ppo != exp_ppo_q) || (core_po != exp_po_q);
  assign fail_next_c = (mismatch_c && (fail_count != {CNT_W{1'b1}}))
                       ? fail_count + CNT_W'(1) : fail_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      sreg          <= '0;
      pat_q         <= '0;
      exp_ppo_q     <= '0;
      exp_po_q      <= 1'b0;
      last_q        <= 1'b0;
      idx           <= '0;
      core_pi       <= 1'b0;
      core_h0       <= 1'b1;
      shift_en      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      pattern_count <= '0;
      fail_count    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pattern_count <= '0;
            fail_count    <= '0;
            pass          <= 1'b0;
            core_h0       <= ~fault_inject;
            busy          <= 1'b1;
            state         <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (pat.pat_valid) begin
            pat_q     <= pat.pat_scan_in;
            core_pi   <= pat.pat_pi;
            exp_po_q  <= pat.exp_po;
            exp_ppo_q <= pat.exp_ppo;
            last_q    <= pat.pat_last;
            idx       <= '0;
            shift_en  <= 1'b1;
            state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // First cell's bit enters first so it ends up at the MSB after CHAIN_LEN shifts.
          sreg <= {sreg[CHAIN_LEN-2:0], pat_q[LAST_IDX - idx]};
          idx  <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            shift_en <= 1'b0;
            state    <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          sreg          <= core_ppo;
          pattern_count <= pattern_count + CNT_W'(1);
          fail_count    <= fail_next_c;
          if (last_q) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_LOAD;
          end
        end
        S_DONE: begin
          pass  <= (fail_count == '0);
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_test_sequencer.sv
// Self-checking bench: table of patterns with a combinational core model and a capture scoreboard.
module tb_scan_test_sequencer;

  localparam int unsigned CL     = 2;
  localparam int unsigned CW     = 2;
  localparam int unsigned BUDGET = 50;
  localparam int unsigned NVEC   = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          fault_inject = 1'b0;
  logic          core_pi, core_h0, core_po;
  logic [CL-1:0] core_ppi, core_ppo;
  logic          shift_en, scan_out, busy, done, pass;
  logic [CW-1:0] pattern_count, fail_count;

  scan_test_sequencer_if #(.CHAIN_LEN(CL)) pat ();

  scan_test_sequencer #(.CHAIN_LEN(CL), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .fault_inject  (fault_inject),
    .pat           (pat),
    .core_pi       (core_pi),
    .core_ppi      (core_ppi),
    .core_h0       (core_h0),
    .core_po       (core_po),
    .core_ppo      (core_ppo),
    .shift_en      (shift_en),
    .scan_out      (scan_out),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .pattern_count (pattern_count),
    .fail_count    (fail_count)
  );

  always #5 clk = ~clk;

  // Core model: H = A & qB (with H_0 gating), B = H, C = ~(A & qB), K = qB & ~H.
  logic h_c;
  always_comb begin
    h_c         = core_pi & core_ppi[1] & core_h0;
    core_ppo[1] = h_c;
    core_ppo[0] = ~(core_pi & core_ppi[1]);
    core_po     = core_ppi[1] & ~h_c;
  end

  typedef struct packed {
    logic          fault;
    logic [CL-1:0] scan_in;
    logic          pi;
    logic          exp_po;
    logic [CL-1:0] exp_ppo;
    logic          last;
    logic          hold;
    logic          poke;
    logic [CL-1:0] cap;
    logic          mm;
  } vec_t;

  typedef struct packed {
    logic [CL-1:0] ppi;
    logic          pi;
    logic          h0;
    logic [CL-1:0] cap;
    logic [CL-1:0] so;
    logic [CW-1:0] pc;
    logic [CW-1:0] fc;
  } exp_t;

  vec_t          vecs [NVEC];
  exp_t          sb_q[$];
  logic          pass_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            rdy_cnt = 0;
  int            done_cnt = 0;
  logic [CW-1:0] tb_pc, tb_fc;
  logic [CL-1:0] prev_cap;
  logic          sess_fault;
  time           hs_time, last_hs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out after %0d cycles", name, BUDGET);
  endtask

  function automatic vec_t mk(input logic f, input logic [CL-1:0] si, input logic pi,
                              input logic epo, input logic [CL-1:0] eppo, input logic last,
                              input logic hold, input logic poke, input logic [CL-1:0] cap,
                              input logic mm);
    vec_t v;
    v.fault = f;  v.scan_in = si; v.pi = pi; v.exp_po = epo; v.exp_ppo = eppo;
    v.last = last; v.hold = hold; v.poke = poke; v.cap = cap; v.mm = mm;
    return v;
  endfunction

  task automatic start_session(input logic f);
    start        = 1'b1;
    fault_inject = f;
    sess_fault   = f;
    tb_pc        = '0;
    tb_fc        = '0;
    @(posedge clk); #1;
    start        = 1'b0;
    fault_inject = 1'b0;
  endtask

  // Drive one pattern; expectations are queued once the handshake is certain.
  task automatic send(input vec_t v);
    int   n;
    exp_t e;
    n = 0;
    pat.pat_scan_in = v.scan_in;
    pat.pat_pi      = v.pi;
    pat.exp_po      = v.exp_po;
    pat.exp_ppo     = v.exp_ppo;
    pat.pat_last    = v.last;
    pat.pat_valid   = 1'b1;
    @(negedge clk);
    while (!pat.pat_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (!pat.pat_ready) begin
      timeout("handshake");
      pat.pat_valid = 1'b0;
      return;
    end
    tb_pc = CW'(tb_pc + 1);
    if (v.mm && tb_fc != {CW{1'b1}}) tb_fc = CW'(tb_fc + 1);
    e.ppi = v.scan_in; e.pi = v.pi; e.h0 = ~sess_fault; e.cap = v.cap;
    e.so  = prev_cap;  e.pc = tb_pc; e.fc = tb_fc;
    sb_q.push_back(e);
    prev_cap = v.cap;
    if (v.last) pass_q.push_back(tb_fc == '0);
    @(posedge clk); #1;
    hs_time = $time;
    if (!v.hold) pat.pat_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (!done) timeout("done_wait");
  endtask

  // Monitor: checks each capture and each session end against the queues.
  initial begin
    exp_t          cur;
    logic          prev_sh, cap_pend, done_pend, ep;
    int            sh_len;
    logic [CL-1:0] so_vec;
    prev_sh = 1'b0; cap_pend = 1'b0; done_pend = 1'b0; sh_len = 0; so_vec = '0; cur = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_sh = 1'b0; cap_pend = 1'b0; done_pend = 1'b0; sh_len = 0; so_vec = '0;
      end else begin
        if (pat.pat_ready) rdy_cnt++;
        if (cap_pend) begin
          check("sreg_after_capture", 32'(core_ppi), 32'(cur.cap));
          check("pattern_count", 32'(pattern_count), 32'(cur.pc));
          check("fail_count", 32'(fail_count), 32'(cur.fc));
          cap_pend = 1'b0;
        end
        if (done_pend) begin
          if (pass_q.size() == 0) begin
            check("done_expected", 32'(0), 32'(1));
          end else begin
            ep = pass_q.pop_front();
            check("pass", 32'(pass), 32'(ep));
          end
          check("done_width", 32'(done), 32'(0));
          check("busy_after_done", 32'(busy), 32'(0));
          done_pend = 1'b0;
        end
        if (done) begin
          done_cnt++;
          done_pend = 1'b1;
        end
        if (shift_en) begin
          so_vec = {so_vec[CL-2:0], scan_out};
          sh_len++;
        end else if (prev_sh) begin
          if (sb_q.size() == 0) begin
            check("capture_expected", 32'(0), 32'(1));
          end else begin
            cur = sb_q.pop_front();
            check("ppi_at_capture", 32'(core_ppi), 32'(cur.ppi));
            check("core_pi", 32'(core_pi), 32'(cur.pi));
            check("core_h0", 32'(core_h0), 32'(cur.h0));
            check("shift_len", 32'(sh_len), 32'(CL));
            check("scan_out_seq", 32'(so_vec), 32'(cur.so));
            cap_pend = 1'b1;
          end
          sh_len = 0;
        end
        prev_sh = shift_en;
      end
    end
  end

  initial begin
    int rdy_base, sess_n, d0;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_base, sess_n, d0, n;
    //              f  scan   pi epo eppo   last hold poke cap    mm
    vecs[0]  = mk(0, 2'b00, 1, 0, 2'b01, 1, 0, 0, 2'b01, 0);
    vecs[1]  = mk(0, 2'b10, 1, 0, 2'b10, 0, 0, 0, 2'b10, 0);
    vecs[2]  = mk(0, 2'b00, 1, 0, 2'b01, 1, 0, 0, 2'b01, 0);
    vecs[3]  = mk(1, 2'b10, 1, 0, 2'b10, 1, 0, 0, 2'b00, 1);
    vecs[4]  = mk(0, 2'b00, 1, 0, 2'b01, 0, 1, 0, 2'b01, 0);
    vecs[5]  = mk(0, 2'b10, 1, 0, 2'b10, 0, 1, 0, 2'b10, 0);
    vecs[6]  = mk(0, 2'b01, 0, 0, 2'b01, 1, 0, 0, 2'b01, 0);
    vecs[7]  = mk(0, 2'b00, 1, 1, 2'b01, 0, 0, 1, 2'b01, 1);
    vecs[8]  = mk(0, 2'b00, 1, 1, 2'b01, 0, 0, 0, 2'b01, 1);
    vecs[9]  = mk(0, 2'b00, 1, 1, 2'b01, 0, 0, 1, 2'b01, 1);
    vecs[10] = mk(0, 2'b00, 1, 1, 2'b01, 0, 0, 0, 2'b01, 1);
    vecs[11] = mk(0, 2'b00, 1, 1, 2'b01, 1, 0, 0, 2'b01, 1);

    pat.pat_valid = 1'b0; pat.pat_scan_in = '0; pat.pat_pi = 1'b0;
    pat.exp_po = 1'b0; pat.exp_ppo = '0; pat.pat_last = 1'b0;
    prev_cap = '0; tb_pc = '0; tb_fc = '0; sess_fault = 1'b0;
    hs_time = 0; last_hs = 0; rdy_base = 0; sess_n = 0;

    @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_shift_en", 32'(shift_en), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_pass", 32'(pass), 32'(0));
    check("rst_core_h0", 32'(core_h0), 32'(1));
    check("rst_core_pi", 32'(core_pi), 32'(0));
    check("rst_core_ppi", 32'(core_ppi), 32'(0));
    check("rst_pat_ready", 32'(pat.pat_ready), 32'(0));
    check("rst_counts", 32'({pattern_count, fail_count}), 32'(0));
    rst = 1'b0;
    @(negedge clk); #1;

    for (int i = 0; i < int'(NVEC); i++) begin
      if (i == 0 || vecs[i-1].last) begin
        rdy_base = rdy_cnt;
        sess_n   = 0;
        start_session(vecs[i].fault);
      end
      send(vecs[i]);
      sess_n++;
      if (i > 0 && vecs[i-1].hold)
        check("b2b_interval", 32'((hs_time - last_hs) / 10), 32'(CL + 2));
      last_hs = hs_time;
      if (vecs[i].poke) begin
        start = 1'b1; fault_inject = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; fault_inject = 1'b0;
        check("busy_during_start_poke", 32'(busy), 32'(1));
      end
      if (vecs[i].last) begin
        wait_done();
        @(negedge clk); #1;
        check("ready_once_per_pattern", 32'(rdy_cnt - rdy_base), 32'(sess_n));
      end
    end

    // Reset in the middle of SHIFT aborts the session without a done pulse.
    start_session(1'b1);
    send(vecs[3]);
    @(negedge clk);
    check("shift_before_rst", 32'(shift_en), 32'(1));
    #1;
    rst = 1'b1;
    d0  = done_cnt;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_shift_en", 32'(shift_en), 32'(0));
    check("abort_core_h0", 32'(core_h0), 32'(1));
    check("abort_counts", 32'({pattern_count, fail_count}), 32'(0));
    check("abort_ppi", 32'(core_ppi), 32'(0));
    sb_q.delete();
    pass_q.delete();
    prev_cap = '0;
    #1;
    rst = 1'b0;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) n++;
    end
    check("abort_no_done", 32'(done_cnt - d0 + n), 32'(0));
    check("abort_idle_busy", 32'(busy), 32'(0));

    check("sb_drained", 32'(sb_q.size()), 32'(0));
    check("pass_q_drained", 32'(pass_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
